// File: rtl/snes_loader_pkg.sv
// Shared types, constants and address helpers for the SNES cartridge ROM loader.
package snes_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_READY  = 3'd4
    } loader_state_t;

    localparam logic [24:0] HEADER_BYTES    = 25'h200;
    localparam int          HEADER_SIZE_BIT = 9;
    localparam int          ENTRY_W         = 57;

    function automatic logic [24:0] strip_header(input logic [24:0] raw, input logic hdr);
        if (hdr) begin
            strip_header = raw - HEADER_BYTES;
        end else begin
            strip_header = raw;
        end
    endfunction

    function automatic logic in_header(input logic [24:0] raw, input logic hdr);
        in_header = hdr && (raw < HEADER_BYTES);
    endfunction

endpackage

// File: rtl/rom_word_fifo.sv
// Synchronous FIFO of {wr_addr, wr_data} bridge words with a flush; head is
// visible without popping so a word stays resident until both beats finish.
module rom_word_fifo
    import snes_loader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);
    assign head_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/snes_rom_loader.sv
// Splits bridge words into 16-bit SDRAM beats, hides the copier header from
// SDRAM, feeds the parser, and releases the SNES core once parsing settles.
module snes_rom_loader
    import snes_loader_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk_mem_i,
    input  logic        reset_i,
    input  logic [31:0] rom_file_size_i,
    input  logic        start_i,
    input  logic        wr_valid_i,
    input  logic [24:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_ready_o,
    input  logic        load_done_i,
    output logic        mem_req_o,
    output logic [24:0] mem_addr_o,
    output logic [15:0] mem_data_o,
    input  logic        mem_ack_i,
    output logic [24:0] parse_addr_o,
    output logic [15:0] parse_data_o,
    output logic        downloading_o,
    output logic        has_header_o,
    output logic        core_reset_o,
    output logic        cfg_valid_o
);
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;

    loader_state_t      state_q, state_d;
    logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
    logic               has_header_q, has_header_d;
    logic               beat_active_q, beat_active_d;
    logic               half_q, half_d;
    logic               mem_req_q, mem_req_d;
    logic [24:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        mem_data_q, mem_data_d;
    logic [24:0]        parse_addr_q, parse_addr_d;
    logic [15:0]        parse_data_q, parse_data_d;
    logic               downloading_q, core_reset_q, cfg_valid_q;

    logic [ENTRY_W-1:0] head_s;
    logic               fifo_full_s, fifo_empty_s;
    logic               push_s, pop_s, flush_s;
    logic               engine_on_s, beat_done_s, present_s, beat_idle_s;
    logic [24:0]        raw_addr_s;
    logic [15:0]        raw_data_s;
    logic               size_unused_s;

    assign size_unused_s = ^{rom_file_size_i[31:HEADER_SIZE_BIT+1],
                             rom_file_size_i[HEADER_SIZE_BIT-1:0]};

    assign wr_ready_o  = (state_q == ST_LOAD) && !fifo_full_s;
    assign push_s      = wr_valid_i && wr_ready_o;
    assign engine_on_s = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign beat_done_s = beat_active_q && (!mem_req_q || mem_ack_i);
    assign pop_s       = beat_done_s && half_q;
    assign present_s   = engine_on_s && !beat_active_q && !fifo_empty_s;
    assign beat_idle_s = fifo_empty_s && !beat_active_q;
    assign raw_addr_s  = head_s[56:32] + (half_q ? 25'd2 : 25'd0);
    assign raw_data_s  = half_q ? head_s[31:16] : head_s[15:0];

    rom_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_mem_i),
        .reset_i     (reset_i),
        .flush_i     (flush_s),
        .push_i      (push_s),
        .push_data_i ({wr_addr_i, wr_data_i}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Beat engine: present a beat, then leave one idle cycle after it completes.
    always_comb begin
        beat_active_d = beat_active_q;
        half_d        = half_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        parse_addr_d  = parse_addr_q;
        parse_data_d  = parse_data_q;
        if (present_s) begin
            beat_active_d = 1'b1;
            mem_req_d     = !in_header(raw_addr_s, has_header_q);
            mem_addr_d    = strip_header(raw_addr_s, has_header_q);
            mem_data_d    = raw_data_s;
            parse_addr_d  = raw_addr_s;
            parse_data_d  = raw_data_s;
        end else if (beat_done_s) begin
            beat_active_d = 1'b0;
            mem_req_d     = 1'b0;
            half_d        = !half_q;
        end else begin
            beat_active_d = beat_active_q;
        end
    end

    // Load sequencing FSM and settle counter.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        has_header_d = has_header_q;
        flush_s      = 1'b0;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start_i) begin
                    flush_s      = 1'b1;
                    has_header_d = rom_file_size_i[HEADER_SIZE_BIT];
                    state_d      = ST_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (load_done_i && beat_idle_s && !push_s) begin
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else if (load_done_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (beat_idle_s) begin
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_READY;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; status outputs follow the next state.
    always_ff @(posedge clk_mem_i) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= '0;
            has_header_q  <= 1'b0;
            beat_active_q <= 1'b0;
            half_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 25'd0;
            mem_data_q    <= 16'd0;
            parse_addr_q  <= 25'd0;
            parse_data_q  <= 16'd0;
            downloading_q <= 1'b0;
            core_reset_q  <= 1'b1;
            cfg_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            has_header_q  <= has_header_d;
            beat_active_q <= beat_active_d;
            half_q        <= half_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            parse_addr_q  <= parse_addr_d;
            parse_data_q  <= parse_data_d;
            downloading_q <= (state_d == ST_LOAD) || (state_d == ST_DRAIN);
            core_reset_q  <= (state_d != ST_READY);
            cfg_valid_q   <= (state_d == ST_READY);
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign parse_addr_o  = parse_addr_q;
    assign parse_data_o  = parse_data_q;
    assign downloading_o = downloading_q;
    assign has_header_o  = has_header_q;
    assign core_reset_o  = core_reset_q;
    assign cfg_valid_o   = cfg_valid_q;

endmodule

// File: tb/tb_snes_rom_loader.sv
// Directed bench for snes_rom_loader: a beat-list model built from accepted
// words is checked against every SDRAM handshake, plus literal spot checks.
module tb_snes_rom_loader;

    logic        clk;
    logic        reset;
    logic [31:0] rom_file_size;
    logic        start;
    logic        wr_valid;
    logic [24:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready_o;
    logic        load_done;
    logic        mem_req_o;
    logic [24:0] mem_addr_o;
    logic [15:0] mem_data_o;
    logic        mem_ack;
    logic [24:0] parse_addr_o;
    logic [15:0] parse_data_o;
    logic        downloading_o;
    logic        has_header_o;
    logic        core_reset_o;
    logic        cfg_valid_o;

    typedef struct packed {
        logic [24:0] maddr;
        logic [24:0] raddr;
        logic [15:0] data;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    bit          first_taken = 0;
    logic [24:0] first_addr = 25'd0;
    logic [15:0] first_data = 16'd0;
    bit          seen_1fc = 0;
    bit          hdr_m = 0;
    bit          ack_en = 1;

    snes_rom_loader #(.FIFO_DEPTH(4), .SETTLE_CYCLES(4)) dut (
        .clk_mem_i       (clk),
        .reset_i         (reset),
        .rom_file_size_i (rom_file_size),
        .start_i         (start),
        .wr_valid_i      (wr_valid),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .wr_ready_o      (wr_ready_o),
        .load_done_i     (load_done),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_ack_i       (mem_ack),
        .parse_addr_o    (parse_addr_o),
        .parse_data_o    (parse_data_o),
        .downloading_o   (downloading_o),
        .has_header_o    (has_header_o),
        .core_reset_o    (core_reset_o),
        .cfg_valid_o     (cfg_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Zero-wait SDRAM responder, gated by ack_en.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack = mem_req_o && ack_en;
        end
    end

    // Model and compare process.
    initial begin
        bit          pend = 0;
        logic [24:0] p_addr = 25'd0;
        logic [15:0] p_data = 16'd0;
        bit          dl_prev = 0;
        bit          cfg_prev = 0;
        int          since = 0;
        beat_t       b;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                exp_q.delete();
                pend = 0; dl_prev = 0; cfg_prev = 0; since = 0;
            end else begin
                if (wr_valid && wr_ready_o) begin
                    for (int h = 0; h < 2; h++) begin
                        logic [24:0] raw;
                        raw = wr_addr + 25'(2 * h);
                        if (!(hdr_m && raw < 25'h200)) begin
                            b.raddr = raw;
                            b.maddr = hdr_m ? raw - 25'h200 : raw;
                            b.data  = (h == 0) ? wr_data[15:0] : wr_data[31:16];
                            exp_q.push_back(b);
                        end
                    end
                end
                chk("core_reset vs cfg_valid", core_reset_o, !cfg_valid_o);
                if (pend) begin
                    chk("held mem_req", mem_req_o, 1'b1);
                    chk("held mem_addr", mem_addr_o, p_addr);
                    chk("held mem_data", mem_data_o, p_data);
                end
                if (mem_req_o && mem_ack) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected write", exp_q.size(), 1);
                    end else begin
                        b = exp_q.pop_front();
                        chk("mem_addr", mem_addr_o, b.maddr);
                        chk("mem_data", mem_data_o, b.data);
                        chk("parse_addr", parse_addr_o, b.raddr);
                        chk("parse_data", parse_data_o, b.data);
                    end
                    chk("downloading at write", downloading_o, 1'b1);
                    if (!first_taken) begin
                        first_taken = 1;
                        first_addr = mem_addr_o;
                        first_data = mem_data_o;
                    end
                    writes++;
                end
                if (parse_addr_o == 25'h1FC && !mem_req_o && downloading_o) seen_1fc = 1;
                if (dl_prev && !downloading_o) since = 0;
                else since++;
                if (!cfg_prev && cfg_valid_o) chk("settle delay", since, 4);
                pend = mem_req_o && !mem_ack;
                p_addr = mem_addr_o;
                p_data = mem_data_o;
                dl_prev = downloading_o;
                cfg_prev = cfg_valid_o;
            end
        end
    end

    task automatic start_load(input logic [31:0] size);
        rom_file_size = size;
        hdr_m = size[9];
        writes = 0;
        first_taken = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [24:0] a, input logic [31:0] d, input bit with_done);
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        while (!wr_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ready wait", wr_ready_o, 1'b1);
        load_done = with_done;
        @(posedge clk); #1;
        wr_valid = 1'b0; load_done = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        @(posedge clk); #1;
        load_done = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cfg_valid_o && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " cfg_valid"}, cfg_valid_o, 1'b1);
        chk({tag, " beats left"}, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rom_file_size = 32'd0;
        wr_valid = 1'b0; wr_addr = 25'd0; wr_data = 32'd0; load_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst wr_ready", wr_ready_o, 1'b0);
        chk("rst mem_req", mem_req_o, 1'b0);
        chk("rst mem_addr", mem_addr_o, 25'd0);
        chk("rst mem_data", mem_data_o, 16'd0);
        chk("rst parse_addr", parse_addr_o, 25'd0);
        chk("rst parse_data", parse_data_o, 16'd0);
        chk("rst downloading", downloading_o, 1'b0);
        chk("rst has_header", has_header_o, 1'b0);
        chk("rst core_reset", core_reset_o, 1'b1);
        chk("rst cfg_valid", cfg_valid_o, 1'b0);

        // No-header load with latency check on the first word.
        start_load(32'h0008_0000);
        chk("t1 has_header", has_header_o, 1'b0);
        chk("t1 downloading", downloading_o, 1'b1);
        send_word(25'h0, 32'h1111_0000, 0);
        @(negedge clk);
        chk("t1 latency cycle1 mem_req", mem_req_o, 1'b0);
        @(negedge clk);
        chk("t1 latency cycle2 mem_req", mem_req_o, 1'b1);
        @(posedge clk); #1;
        send_word(25'h4, 32'h3333_2222, 0);
        send_word(25'h8, 32'h5555_4444, 0);
        send_word(25'hC, 32'h7777_6666, 0);
        pulse_done();
        wait_ready("t1");
        chk("t1 writes", writes, 8);
        chk("t1 first addr", first_addr, 25'h0);
        chk("t1 first data", first_data, 16'h0000);
        chk("t1 core_reset", core_reset_o, 1'b0);

        // Headered load.
        start_load(32'h0008_0200);
        chk("t2 has_header", has_header_o, 1'b1);
        chk("t2 cfg_valid fell", cfg_valid_o, 1'b0);
        seen_1fc = 0;
        send_word(25'h1FC, 32'hAAAA_BBBB, 0);
        send_word(25'h200, 32'h1234_5678, 0);
        pulse_done();
        wait_ready("t2");
        chk("t2 writes", writes, 2);
        chk("t2 first addr", first_addr, 25'h0);
        chk("t2 first data", first_data, 16'h5678);
        chk("t2 header beat shown", seen_1fc, 1'b1);

        // Backpressure: ack held low for 20 cycles.
        start_load(32'h0008_0000);
        ack_en = 0;
        send_word(25'h0, 32'hB1B1_A0A0, 0);
        send_word(25'h4, 32'hB3B3_A2A2, 0);
        send_word(25'h8, 32'hB5B5_A4A4, 0);
        send_word(25'hC, 32'hB7B7_A6A6, 0);
        chk("t3 full wr_ready", wr_ready_o, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t3 stall mem_req", mem_req_o, 1'b1);
        chk("t3 stall mem_addr", mem_addr_o, 25'h0);
        chk("t3 stall mem_data", mem_data_o, 16'hA0A0);
        ack_en = 1;
        pulse_done();
        wait_ready("t3");
        chk("t3 writes", writes, 8);

        // load_done together with the last word.
        start_load(32'h0008_0000);
        send_word(25'h0, 32'hC1C1_C0C0, 0);
        send_word(25'h4, 32'hC3C3_C2C2, 1);
        wait_ready("t4");
        chk("t4 writes", writes, 4);

        // Reset during DRAIN, then a fresh headered load.
        start_load(32'h0008_0000);
        ack_en = 0;
        send_word(25'h0, 32'hD1D1_D0D0, 0);
        send_word(25'h4, 32'hD3D3_D2D2, 0);
        pulse_done();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5 mem_req", mem_req_o, 1'b0);
        chk("t5 mem_addr", mem_addr_o, 25'd0);
        chk("t5 parse_addr", parse_addr_o, 25'd0);
        chk("t5 downloading", downloading_o, 1'b0);
        chk("t5 core_reset", core_reset_o, 1'b1);
        chk("t5 wr_ready", wr_ready_o, 1'b0);
        ack_en = 1;
        start_load(32'h0010_0200);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5 fifo empty after reset", mem_req_o, 1'b0);
        end
        send_word(25'h200, 32'hE1E1_E0E0, 0);
        send_word(25'h204, 32'hE3E3_E2E2, 0);
        pulse_done();
        wait_ready("t5");
        chk("t5 writes", writes, 4);
        chk("t5 first addr", first_addr, 25'h0);

        // start during SETTLE is ignored.
        start_load(32'h0008_0000);
        send_word(25'h0, 32'hF1F1_F0F0, 1);
        begin
            int n = 0;
            while (downloading_o && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t6 reached settle", downloading_o, 1'b0);
        end
        rom_file_size = 32'h0008_0200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_ready("t6");
        chk("t6 has_header kept", has_header_o, 1'b0);

        // start during READY restarts; empty load goes straight to SETTLE.
        start_load(32'h0008_0000);
        chk("t7 cfg_valid fell", cfg_valid_o, 1'b0);
        chk("t7 core_reset rose", core_reset_o, 1'b1);
        pulse_done();
        chk("t7 direct settle", downloading_o, 1'b0);
        wait_ready("t7");
        chk("t7 writes", writes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
